// File: rtl/wam_lvl_ctl.sv
// wam_lvl_ctl - debounced, saturating game level controller.
//
// Holds the current level (0..LVL_MAX) and moves it one step easier on a
// debounced lft press, one step harder on a debounced rgt press or a rising
// edge of the score carry cout0. A ld strobe loads ld_lvl directly (clamped
// to LVL_MAX). The level never wraps at either end.
//
// Optional build macro: WAM_LVL_AUTOREP_EN adds hold-to-repeat on lft/rgt.
//
// Ports:
//   clk_19  in   1      game tick clock
//   clr     in   1      asynchronous active-high reset
//   lft     in   1      raw button, easier
//   rgt     in   1      raw button, harder
//   cout0   in   1      score carry (synchronous), harder on rising edge
//   ld      in   1      one-cycle load strobe
//   ld_lvl  in   LVL_W  level to load
//   hrdn    out  LVL_W  current level
//   at_min  out  1      hrdn == 0
//   at_max  out  1      hrdn == LVL_MAX
//   chg     out  1      one-cycle pulse when hrdn changed

// Per-button synchroniser plus debounce FSM; ev is a one-cycle press event.
module wam_lvl_db #(
  parameter int unsigned DB_CNT  = 4,
  parameter int unsigned DB_W    = 4
`ifdef WAM_LVL_AUTOREP_EN
  ,
  parameter int unsigned REP_DLY = 16,
  parameter int unsigned REP_PER = 4,
  parameter int unsigned REP_W   = 6
`endif
) (
  input  logic clk_19,
  input  logic clr,
  input  logic raw,
  output logic ev
);

  typedef enum logic [1:0] {IDLE, FILT, HELD} db_state_t;

  db_state_t       st, st_nxt;
  logic            s1, sync;
  logic [DB_W-1:0] cnt, cnt_nxt;
`ifdef WAM_LVL_AUTOREP_EN
  logic [REP_W-1:0] rcnt, rcnt_nxt;
  logic             armed, armed_nxt;
`endif

  always_ff @(posedge clk_19 or posedge clr) begin
    if (clr) begin
      s1    <= 1'b0;
      sync  <= 1'b0;
      st    <= IDLE;
      cnt   <= '0;
`ifdef WAM_LVL_AUTOREP_EN
      rcnt  <= '0;
      armed <= 1'b0;
`endif
    end else begin
      s1    <= raw;
      sync  <= s1;
      st    <= st_nxt;
      cnt   <= cnt_nxt;
`ifdef WAM_LVL_AUTOREP_EN
      rcnt  <= rcnt_nxt;
      armed <= armed_nxt;
`endif
    end
  end

  // The accepting event is combinational on the last FILT cycle so the level
  // updates on the same edge that moves the FSM into HELD.
  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    ev        = 1'b0;
`ifdef WAM_LVL_AUTOREP_EN
    rcnt_nxt  = '0;
    armed_nxt = 1'b0;
`endif
    case (st)
      IDLE: begin
        if (sync) begin
          st_nxt  = FILT;
          cnt_nxt = DB_W'(1);
        end
      end
      FILT: begin
        if (!sync) begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end else if (cnt == DB_W'(DB_CNT)) begin
          ev      = 1'b1;
          st_nxt  = HELD;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (!sync) begin
          st_nxt = IDLE;
        end
`ifdef WAM_LVL_AUTOREP_EN
        // rcnt counts held cycles since entry (or since the last repeat);
        // armed selects the first-repeat delay versus the repeat period.
        else if (rcnt == (armed ? REP_W'(REP_PER - 1) : REP_W'(REP_DLY - 1))) begin
          ev        = 1'b1;
          armed_nxt = 1'b1;
        end else begin
          rcnt_nxt  = rcnt + REP_W'(1);
          armed_nxt = armed;
        end
`endif
      end
      default: st_nxt = IDLE;
    endcase
  end

endmodule

module wam_lvl_ctl #(
  parameter int unsigned LVL_W   = 4,
  parameter int unsigned LVL_MAX = 10,
  parameter int unsigned DB_CNT  = 4,
  parameter int unsigned DB_W    = 4,
  parameter int unsigned REP_DLY = 16,
  parameter int unsigned REP_PER = 4,
  parameter int unsigned REP_W   = 6
) (
  input  logic             clk_19,
  input  logic             clr,
  input  logic             lft,
  input  logic             rgt,
  input  logic             cout0,
  input  logic             ld,
  input  logic [LVL_W-1:0] ld_lvl,
  output logic [LVL_W-1:0] hrdn,
  output logic             at_min,
  output logic             at_max,
  output logic             chg
);

  localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(LVL_MAX);

  generate
    if (LVL_MAX >= 2**LVL_W || DB_CNT < 1 || DB_CNT >= 2**DB_W ||
        REP_DLY < 1 || REP_PER < 1 ||
        REP_DLY >= 2**REP_W || REP_PER >= 2**REP_W) begin : g_bad_params
      $error("wam_lvl_ctl: parameter out of range");
    end
  endgenerate

  logic             ev_l, ev_r, ev_c, ev_e, ev_h;
  logic             c_d;
  logic [LVL_W-1:0] nxt;

  wam_lvl_db #(
    .DB_CNT  (DB_CNT),
    .DB_W    (DB_W)
`ifdef WAM_LVL_AUTOREP_EN
    ,
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER),
    .REP_W   (REP_W)
`endif
  ) u_db_lft (
    .clk_19 (clk_19),
    .clr    (clr),
    .raw    (lft),
    .ev     (ev_l)
  );

  wam_lvl_db #(
    .DB_CNT  (DB_CNT),
    .DB_W    (DB_W)
`ifdef WAM_LVL_AUTOREP_EN
    ,
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER),
    .REP_W   (REP_W)
`endif
  ) u_db_rgt (
    .clk_19 (clk_19),
    .clr    (clr),
    .raw    (rgt),
    .ev     (ev_r)
  );

  assign ev_c = cout0 & ~c_d;
  assign ev_e = ev_l;
  assign ev_h = ev_r | ev_c;

  // Priority ld > easier > harder; a losing harder event is simply dropped.
  always_comb begin
    nxt = hrdn;
    if (ld) begin
      nxt = (ld_lvl > LVL_TOP) ? LVL_TOP : ld_lvl;
    end else if (ev_e) begin
      if (hrdn != '0) nxt = hrdn - LVL_W'(1);
    end else if (ev_h) begin
      if (hrdn < LVL_TOP) nxt = hrdn + LVL_W'(1);
    end
  end

  always_ff @(posedge clk_19 or posedge clr) begin
    if (clr) begin
      hrdn   <= '0;
      at_min <= 1'b1;
      at_max <= 1'b0;
      chg    <= 1'b0;
      c_d    <= 1'b0;
    end else begin
      hrdn   <= nxt;
      at_min <= (nxt == '0);
      at_max <= (nxt == LVL_TOP);
      chg    <= (nxt != hrdn);
      c_d    <= cout0;
    end
  end

endmodule
